// File: rtl/cache_structs_def.sv
// Shared cache/memory bundle types.
// Includes the arbiter state encoding and the default requester-id width.
package cache_structs_def;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 128;

  typedef struct packed {
    logic                  cs;
    logic                  rw;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } memory_request_t;

  typedef struct packed {
    logic                  ack;
    logic [DATA_WIDTH-1:0] data;
  } memory_response_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  localparam int N_REQ_DEFAULT = 2;
  localparam int REQ_ID_WIDTH  = $clog2(N_REQ_DEFAULT);

endpackage

// File: rtl/rr_picker.sv
// Round-robin priority encoder.
// Searches upward from the slot after last_grant, wrapping at N_REQ.
module rr_picker #(
  parameter int N_REQ = 2,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_vec,
  input  logic [ID_W-1:0]  last_grant,
  output logic [ID_W-1:0]  winner,
  output logic             any
);

  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = ID_W'((int'(last_grant) + i) % N_REQ);
      if (!found && req_vec[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
    any = found;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among N_REQ caches.
// Winner's request is buffered; ack is routed back to the owner only.
module mem_arbiter
  import cache_structs_def::*;
#(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int ID_W          = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  memory_request_t  req [N_REQ],
  output memory_response_t res [N_REQ],
  output memory_request_t  mem_req,
  input  memory_response_t mem_res,
  output logic [ID_W-1:0]  grant_id,
  output logic             busy,
  output logic             timeout_err
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

  arb_state_t      state_q;
  arb_state_t      state_d;
  memory_request_t req_buf;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] winner;
  logic            any;
  logic [N_REQ-1:0] cs_vec;
  logic [WD_W-1:0] wd_cnt;

  always_comb begin
    cs_vec = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cs_vec[i] = req[i].cs;
    end
  end

  rr_picker #(
    .N_REQ(N_REQ)
  ) u_picker (
    .req_vec   (cs_vec),
    .last_grant(last_grant),
    .winner    (winner),
    .any       (any)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (any) state_d = ARB_BUSY;
      ARB_BUSY: if (mem_res.ack) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      req_buf     <= '0;
      grant_id    <= '0;
      last_grant  <= ID_W'(N_REQ - 1);
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else if (state_q == ARB_IDLE && any) begin
      req_buf    <= req[winner];
      grant_id   <= winner;
      last_grant <= winner;
      wd_cnt     <= '0;
    end else if (state_q == ARB_BUSY && !mem_res.ack
                 && TIMEOUT_CYCLES != 0) begin
      // Counter saturates at the threshold; the flag is sticky.
      if (wd_cnt == WD_MAX) begin
        timeout_err <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    busy    = (state_q == ARB_BUSY);
    mem_req = '0;
    if (busy) begin
      mem_req    = req_buf;
      mem_req.cs = !mem_res.ack;
    end
    for (int i = 0; i < N_REQ; i++) begin
      res[i].data = mem_res.data;
      res[i].ack  = busy && mem_res.ack && (grant_id == ID_W'(i));
    end
  end

endmodule
